// File: rtl/jt49_pkg.sv
// Shared types and defaults for the jt49 period measurement block.
// Optional build macro JT49_PMEAS_SYNC_EN is consumed by jt49_edge_det.
package jt49_pkg;

  localparam int JT49_PMEAS_W = 12;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } pmeas_state_t;

endpackage

// File: rtl/jt49_edge_det.sv
// Both-polarity edge detector for the measured square wave.
// Define JT49_PMEAS_SYNC_EN to insert a 2-flop synchronizer ahead of the delay flop.
module jt49_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic div_in,
  output logic div_edge
);

  logic div_s;
  logic div_d_reg;

`ifdef JT49_PMEAS_SYNC_EN
  logic [1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], div_in};
    end
  end

  assign div_s = sync_reg[1];
`else
  assign div_s = div_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      div_d_reg <= 1'b0;
    end else begin
      div_d_reg <= div_s;
    end
  end

  assign div_edge = div_s ^ div_d_reg;

endmodule

// File: rtl/jt49_period_meas.sv
// Measures the half-period of div_in in cen ticks and hands results out over valid/ready.
// Build with JT49_PMEAS_SYNC_EN when div_in comes from another clock domain.
module jt49_period_meas
  import jt49_pkg::*;
#(
  parameter int W = JT49_PMEAS_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cen,
  input  logic         en,
  input  logic         div_in,
  output logic [W-1:0] period,
  output logic         ovf,
  output logic         valid,
  input  logic         ready,
  output logic         overrun
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic         div_edge;
  pmeas_state_t state_reg, state_next;
  logic [W-1:0] cnt_reg, cnt_next;
  logic [W-1:0] period_reg, period_next;
  logic         ovf_reg, ovf_next;
  logic         valid_reg, valid_next;
  logic         overrun_reg, overrun_next;
  logic         capture;
  logic [W:0]   sum;
  logic [W-1:0] result_sat;

  jt49_edge_det u_edge_det (
    .clk      (clk),
    .rst      (rst),
    .div_in   (div_in),
    .div_edge (div_edge)
  );

  // The edge cycle itself counts when cen is high, hence cnt+cen.
  assign sum        = {1'b0, cnt_reg} + {{W{1'b0}}, cen};
  assign result_sat = sum[W] ? CNT_MAX : sum[W-1:0];

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    period_next  = period_reg;
    ovf_next     = ovf_reg;
    valid_next   = valid_reg;
    overrun_next = overrun_reg;
    capture      = 1'b0;

    if (!en) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (div_edge) begin
            state_next = MEAS;
            cnt_next   = '0;
          end
        end
        MEAS: begin
          if (div_edge) begin
            capture  = 1'b1;
            cnt_next = '0;
          end else if (cen && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // A capture always wins over acceptance; only an unaccepted result counts as overrun.
    if (capture) begin
      period_next = result_sat;
      ovf_next    = (cnt_reg == CNT_MAX);
      valid_next  = 1'b1;
      if (valid_reg && !ready) begin
        overrun_next = 1'b1;
      end
    end else if (valid_reg && ready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      period_reg  <= '0;
      ovf_reg     <= 1'b0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      period_reg  <= period_next;
      ovf_reg     <= ovf_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
    end
  end

  assign period  = period_reg;
  assign ovf     = ovf_reg;
  assign valid   = valid_reg;
  assign overrun = overrun_reg;

endmodule

// File: tb/tb_jt49_period_meas.sv
// Self-checking bench for jt49_period_meas: table-driven periodic vectors with a
// scoreboard, plus hand-written handshake, reset and enable sequences.
module tb_jt49_period_meas;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        en;
  logic        div_in;
  logic        ready;
  logic [11:0] period_a;
  logic        ovf_a, valid_a, overrun_a;
  logic [3:0]  period_b;
  logic        ovf_b, valid_b, overrun_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int cd;
    int hp;
    int n_edges;
    int exp12;
    int ovf12;
    int exp4;
    int ovf4;
  } vec_t;

  typedef struct {
    int p;
    int o;
  } res_t;

  vec_t vecs[5];
  res_t q12[$];
  res_t q4[$];
  res_t ra, rb;
  bit   mon_en    = 1'b0;
  bit   have_last = 1'b0;
  int   last_acc  = 0;
  int   exp_gap   = 0;

  jt49_period_meas #(.W(12)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .en      (en),
    .div_in  (div_in),
    .period  (period_a),
    .ovf     (ovf_a),
    .valid   (valid_a),
    .ready   (ready),
    .overrun (overrun_a)
  );

  jt49_period_meas #(.W(4)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .en      (en),
    .div_in  (div_in),
    .period  (period_b),
    .ovf     (ovf_b),
    .valid   (valid_b),
    .ready   (ready),
    .overrun (overrun_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end else begin
      $display("ok   %s value=%0d t=%0t", name, act, $time);
    end
  endtask

  task automatic tick(input logic c, input logic t);
    cen = c;
    if (t) div_in = ~div_in;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    div_in = 1'b0;
    ready  = 1'b0;
    en     = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // Scoreboard: results are popped when the consumer accepts them.
  always @(negedge clk) begin
    if (mon_en && valid_a && ready) begin
      if (q12.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result_a actual=%0d expected=none", period_a);
      end else begin
        ra = q12.pop_front();
        chk("sb_period_a", 32'(period_a), ra.p);
        chk("sb_ovf_a", 32'(ovf_a), ra.o);
        if (have_last) chk("sb_gap_a", cyc - last_acc, exp_gap);
        have_last = 1'b1;
        last_acc  = cyc;
      end
    end
    if (mon_en && valid_b && ready) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result_b actual=%0d expected=none", period_b);
      end else begin
        rb = q4.pop_front();
        chk("sb_period_b", 32'(period_b), rb.p);
        chk("sb_ovf_b", 32'(ovf_b), rb.o);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int per;
    int total;
    logic tg;

    vecs[0] = '{1,   5, 6,   5, 0,  5, 0};
    vecs[1] = '{3, 100, 3, 100, 0, 15, 1};
    vecs[2] = '{1,   7, 5,   7, 0,  7, 0};
    vecs[3] = '{2,   9, 4,   9, 0,  9, 0};
    vecs[4] = '{1,  20, 3,  20, 0, 15, 1};

    rst = 1'b1; cen = 1'b0; en = 1'b0; div_in = 1'b0; ready = 1'b0;
    do_reset();
    chk("rst_period", 32'(period_a), 0);
    chk("rst_ovf", 32'(ovf_a), 0);
    chk("rst_valid", 32'(valid_a), 0);
    chk("rst_overrun", 32'(overrun_a), 0);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      en        = 1'b1;
      ready     = 1'b1;
      per       = vecs[v].hp * vecs[v].cd;
      total     = vecs[v].n_edges * per;
      exp_gap   = per;
      have_last = 1'b0;
      mon_en    = 1'b1;
      for (int c = 0; c < total + 4; c++) begin
        tg = ((c % per) == 0) && (c < total);
        if (tg && c > 0) begin
          q12.push_back('{vecs[v].exp12, vecs[v].ovf12});
          q4.push_back('{vecs[v].exp4, vecs[v].ovf4});
        end
        tick((c % vecs[v].cd) == 0, tg);
      end
      mon_en = 1'b0;
      chk("drain_a", q12.size(), 0);
      chk("drain_b", q4.size(), 0);
      q12.delete();
      q4.delete();
    end

    // Two captures without acceptance: overwrite and sticky overrun.
    do_reset();
    en = 1'b1;
    tick(1'b1, 1'b1);
    chk("first_edge_discard", 32'(valid_a), 0);
    repeat (5) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("ovr_first_valid", 32'(valid_a), 1);
    chk("ovr_first_period", 32'(period_a), 6);
    chk("ovr_first_overrun", 32'(overrun_a), 0);
    repeat (3) tick(1'b1, 1'b0);
    chk("ovr_hold_period", 32'(period_a), 6);
    chk("ovr_hold_valid", 32'(valid_a), 1);
    repeat (4) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("ovr_second_valid", 32'(valid_a), 1);
    chk("ovr_second_period", 32'(period_a), 8);
    chk("ovr_second_overrun", 32'(overrun_a), 1);
    ready = 1'b1;
    tick(1'b1, 1'b0);
    chk("ovr_accept_valid", 32'(valid_a), 0);
    chk("ovr_sticky", 32'(overrun_a), 1);
    repeat (3) tick(1'b1, 1'b0);
    chk("ovr_sticky_later", 32'(overrun_a), 1);
    do_reset();
    chk("ovr_cleared_by_rst", 32'(overrun_a), 0);
    chk("rst_period_after", 32'(period_a), 0);

    // Capture coinciding with acceptance.
    do_reset();
    en = 1'b1;
    tick(1'b1, 1'b1);
    repeat (4) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("coin_first_period", 32'(period_a), 5);
    repeat (3) tick(1'b1, 1'b0);
    ready = 1'b1;
    tick(1'b1, 1'b1);
    ready = 1'b0;
    chk("coin_valid", 32'(valid_a), 1);
    chk("coin_period", 32'(period_a), 4);
    chk("coin_overrun", 32'(overrun_a), 0);
    ready = 1'b1;
    tick(1'b1, 1'b0);
    chk("coin_drop", 32'(valid_a), 0);

    // Reset in mid-interval discards the partial count.
    do_reset();
    en    = 1'b1;
    ready = 1'b1;
    tick(1'b1, 1'b1);
    repeat (3) tick(1'b1, 1'b0);
    rst = 1'b1;
    tick(1'b1, 1'b1);
    rst = 1'b0;
    repeat (2) tick(1'b1, 1'b0);
    chk("mid_rst_quiet", 32'(valid_a), 0);
    tick(1'b1, 1'b1);
    chk("mid_rst_first_edge", 32'(valid_a), 0);
    repeat (6) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("mid_rst_valid", 32'(valid_a), 1);
    chk("mid_rst_period", 32'(period_a), 7);

    // Edge on a cen=0 cycle still captures, without the extra tick.
    do_reset();
    en = 1'b1;
    tick(1'b1, 1'b1);
    repeat (4) tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    chk("cen0_valid", 32'(valid_a), 1);
    chk("cen0_period_a", 32'(period_a), 4);
    chk("cen0_period_b", 32'(period_b), 4);

    // en=0 keeps the pending result; re-enabling discards the first edge.
    en = 1'b0;
    tick(1'b1, 1'b1);
    repeat (3) tick(1'b1, 1'b0);
    chk("en0_valid_kept", 32'(valid_a), 1);
    chk("en0_period_kept", 32'(period_a), 4);
    en = 1'b1;
    tick(1'b1, 1'b1);
    chk("reen_first_discard", 32'(period_a), 4);
    repeat (2) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("reen_period", 32'(period_a), 3);
    chk("reen_overrun", 32'(overrun_a), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jt49_period_meas.md
JT49_PERIOD_MEAS -- requirements
Module: jt49_period_meas

Interface
REQ-001 SHALL have parameter W, default 12, meaning the width of the measured period and the counter.
REQ-002 SHALL have port clk, input, 1, the system clock.
REQ-003 SHALL have port rst, input, 1; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port cen, input, 1, the tick enable; the module counts only cycles with cen=1.
REQ-005 SHALL have port en, input, 1, which enables measurement; 0 forces the IDLE state.
REQ-006 SHALL have port div_in, input, 1, the square wave under measurement (a divider output).
REQ-007 SHALL have port period, output, W, the last measured half-period in cen ticks.
REQ-008 SHALL have port ovf, output, 1, set when the period result is saturated.
REQ-009 SHALL have port valid, output, 1, indicating that period/ovf hold an unread result.
REQ-010 SHALL have port ready, input, 1, the consumer accept signal.
REQ-011 SHALL have port overrun, output, 1, a sticky flag: a result was replaced before it was accepted.

Function
REQ-012 SHALL register div_in every clk into div_d; edge = div_in XOR div_d (both polarities).
REQ-013 SHALL implement states IDLE and MEAS.
REQ-014 IDLE -> MEAS on the first edge with en=1; cnt cleared to 0; no result produced (first partial interval discarded).
REQ-015 In MEAS, cnt SHALL increment on each cycle with cen=1 and no edge, saturating at all-ones.
REQ-016 On an edge in MEAS, result SHALL equal cnt+cen, saturated to all-ones; on the same cycle cnt is cleared to 0.
REQ-017 On the cycle after the edge, the result SHALL appear on period and valid SHALL be 1; latency is one clk from edge detection.
REQ-018 ovf SHALL be 1 when the captured result saturated (cnt reached all-ones before the edge).
REQ-019 Handshake: a result is accepted on a cycle with valid=1 and ready=1; valid SHALL drop next cycle unless a new result is loaded on the same cycle.
REQ-020 period/ovf SHALL stay stable while valid=1 and no new capture occurs.
REQ-021 If a new capture occurs while valid=1 and ready=0, period/ovf SHALL be overwritten, valid SHALL stay 1, and overrun SHALL be set.
REQ-022 If a capture coincides with acceptance, the new result SHALL load, valid SHALL stay 1, and overrun SHALL NOT be set.
REQ-023 overrun SHALL clear only on rst.
REQ-024 en=0 SHALL return the block to IDLE and clear cnt; the pending valid/period SHALL be retained until accepted.
REQ-025 An edge with cen=0 on the edge cycle SHALL still capture (result=cnt).

Reset
REQ-026 On rst: state=IDLE, cnt=0, div_d=0, period=0, ovf=0, valid=0, overrun=0.
REQ-027 rst mid-measurement SHALL discard the partial count; the next edge after reset is treated as the first edge.

Configuration
REQ-028 Macro JT49_PMEAS_SYNC_EN: when defined, div_in SHALL pass through a 2-flop synchronizer before div_d, adding 2 clk of edge latency, with synchronizer flops reset to 0.
REQ-029 Without JT49_PMEAS_SYNC_EN, div_in SHALL feed div_d directly (same-clock-domain source).

Structure
REQ-030 The shared package jt49_pkg SHALL hold the state enum (IDLE, MEAS) and the default W constant.
REQ-031 The edge detector (plus optional synchronizer) SHALL be a sub-module, jt49_edge_det.

Verification
REQ-032 cen=1 always, divider period=5 drives div_in -> after the first discarded edge, each result is period=5, ovf=0.
REQ-033 cen every 3rd clk, divider period=100 -> period=100, with valid pulses spaced 300 clk apart.
REQ-034 W=4, half-period of 20 cen ticks -> period=15, ovf=1.
REQ-035 ready=0 across two captures -> valid stays 1, period shows the second value, overrun=1; overrun persists after ready=1 until rst.
REQ-036 rst asserted mid-interval, then edges 7 ticks apart -> no result for the first post-reset edge, then period=7.
REQ-037 Capture and ready=1 on the same cycle -> valid stays 1 with the new value and overrun=0.
